// File: rtl/pq_pkg.sv
// Shared key/value types and constants for the priority queue and its request sequencer.
package pq_pkg;

   localparam int KEY_W = 8;
   localparam int VAL_W = 8;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] value;
   } kv_t;

   localparam logic [KEY_W-1:0] KEY0   = '0;
   localparam logic [KEY_W-1:0] KEYINF = '1;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_ENQ  = 2'b01,
      OP_DEQ  = 2'b10,
      OP_REPL = 2'b11
   } op_t;

endpackage

// File: rtl/pq_req_seq_if.sv
// Request, response and PQ device-side signals of the request sequencer.
// The sequencer is the slave of the request channel and drives the PQ strobes.
interface pq_req_seq_if;

   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   pq_pkg::kv_t req_kv;

   logic        pq_enq;
   logic        pq_deq;
   pq_pkg::kv_t pq_kvi;
   pq_pkg::kv_t pq_kvo;
   logic        pq_full;
   logic        pq_empty;
   logic        pq_busy;

   logic        rsp_valid;
   logic        rsp_ready;
   pq_pkg::kv_t rsp_kv;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_op, req_kv,
      input  pq_kvo, pq_full, pq_empty, pq_busy,
      input  rsp_ready,
      output req_ready,
      output pq_enq, pq_deq, pq_kvi,
      output rsp_valid, rsp_kv, rsp_err
   );

   modport master (
      output req_valid, req_op, req_kv,
      output pq_kvo, pq_full, pq_empty, pq_busy,
      output rsp_ready,
      input  req_ready,
      input  pq_enq, pq_deq, pq_kvi,
      input  rsp_valid, rsp_kv, rsp_err
   );

endinterface

// File: rtl/pq_req_seq.sv
// Request sequencer in front of the shift-register PQ: buffers ENQ/DEQ/REPLACE commands,
// issues them when the PQ can accept, and returns one response per legal command.
module pq_req_seq
   import pq_pkg::*;
#(
   parameter int CMD_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   pq_req_seq_if.slave                bus,
   output logic [$clog2(CMD_DEPTH):0] cmd_count
);

   localparam int AW = $clog2(CMD_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(CMD_DEPTH);
   localparam kv_t KV_EMPTY = '{key: KEYINF, value: '0};

   typedef struct packed {
      op_t op;
      kv_t kv;
   } cmd_t;

   typedef enum logic {
      IDLE,
      REPL_ENQ
   } state_t;

   cmd_t          mem [CMD_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   cmd_t          head;
   logic          push;
   logic          pop;
   logic          issue_ok;

   state_t        state;
   state_t        state_nxt;
   kv_t           held_kv;
   logic          held_load;
   logic          rsp_load;
   kv_t           rsp_kv_nxt;
   logic          rsp_err_nxt;

   assign bus.req_ready = !rst && (cmd_count != DEPTH_CNT);
   assign push          = bus.req_valid && bus.req_ready;
   assign head          = mem[rd_ptr];
   assign issue_ok      = !rst && (state == IDLE) && (cmd_count != '0) && !bus.pq_busy &&
                          (!bus.rsp_valid || bus.rsp_ready);

   // NOTE: sequential state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cmd_count <= cmd_count + 1'b1;
            2'b01:   cmd_count <= cmd_count - 1'b1;
            default: cmd_count <= cmd_count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers alone decide which
   // entries are valid, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{op: op_t'(bus.req_op), kv: bus.req_kv};
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      bus.pq_enq  = 1'b0;
      bus.pq_deq  = 1'b0;
      bus.pq_kvi  = head.kv;
      rsp_load    = 1'b0;
      rsp_kv_nxt  = bus.rsp_kv;
      rsp_err_nxt = bus.rsp_err;
      held_load   = 1'b0;

      unique case (state)
         IDLE: begin
            if (issue_ok) begin
               pop = 1'b1;
               case (head.op)
                  OP_ENQ: begin
                     rsp_load    = 1'b1;
                     rsp_kv_nxt  = head.kv;
                     rsp_err_nxt = bus.pq_full;
                     bus.pq_enq  = !bus.pq_full;
                  end
                  OP_DEQ: begin
                     rsp_load = 1'b1;
                     if (bus.pq_empty) begin
                        rsp_kv_nxt  = KV_EMPTY;
                        rsp_err_nxt = 1'b1;
                     end else begin
                        bus.pq_deq  = 1'b1;
                        rsp_kv_nxt  = bus.pq_kvo;
                        rsp_err_nxt = 1'b0;
                     end
                  end
                  OP_REPL: begin
                     rsp_load = 1'b1;
                     if (bus.pq_empty) begin
                        // Nothing to replace: insert the new pair and flag the empty case.
                        bus.pq_enq  = 1'b1;
                        rsp_kv_nxt  = KV_EMPTY;
                        rsp_err_nxt = 1'b1;
                     end else begin
                        // The PQ drops enq while deq is high, so the insert follows next cycle.
                        bus.pq_deq  = 1'b1;
                        rsp_kv_nxt  = bus.pq_kvo;
                        rsp_err_nxt = 1'b0;
                        held_load   = 1'b1;
                        state_nxt   = REPL_ENQ;
                     end
                  end
                  default: ;
               endcase
            end
         end
         REPL_ENQ: begin
            bus.pq_kvi = held_kv;
            if (!rst && !bus.pq_busy) begin
               bus.pq_enq = 1'b1;
               state_nxt  = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         held_kv       <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_kv    <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (held_load) held_kv <= head.kv;
         if (rsp_load) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_kv    <= rsp_kv_nxt;
            bus.rsp_err   <= rsp_err_nxt;
         end else if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
         end
      end
   end

   a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
      !(bus.pq_enq && bus.pq_deq));
   a_strobe_busy: assert property (@(posedge clk) disable iff (rst)
      bus.pq_busy |-> !(bus.pq_enq || bus.pq_deq));

endmodule

// File: tb/tb_pq_req_seq.sv
// Randomised and directed bench for pq_req_seq: a behavioural PQ device, a command-level
// reference model feeding an expected-response queue, and a decoupled response monitor.
module tb_pq_req_seq;
   import pq_pkg::*;

   localparam int CMD_DEPTH = 4;
   localparam int PQ_CAP    = 4;
   localparam kv_t EXP_EMPTY = '{key: {KEY_W{1'b1}}, value: '0};

   typedef struct packed {
      kv_t  kv;
      logic err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pq_req_seq_if bus ();
   logic [$clog2(CMD_DEPTH):0] cmd_count;

   pq_req_seq #(.CMD_DEPTH(CMD_DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .cmd_count (cmd_count)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic kv_t mk(input int k, input int v);
      kv_t r;
      r.key   = KEY_W'(k);
      r.value = VAL_W'(v);
      return r;
   endfunction

   // Behavioural PQ device: sorted by key, ties kept in arrival order, deq wins over enq.
   kv_t dev_q[$];
   int  dev_size = 0;
   kv_t dev_head = '0;
   int  dev_pos;
   bit  dev_found;
   int  n_enq = 0, n_deq = 0, cyc = 0, last_enq_cyc = 0, last_deq_cyc = 0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         dev_q.delete();
      end else if (bus.pq_deq) begin
         if (dev_q.size() > 0) void'(dev_q.pop_front());
         n_deq++;
         last_deq_cyc = cyc;
      end else if (bus.pq_enq) begin
         dev_pos   = dev_q.size();
         dev_found = 1'b0;
         for (int i = 0; i < dev_q.size(); i++) begin
            if (!dev_found && dev_q[i].key > bus.pq_kvi.key) begin
               dev_pos   = i;
               dev_found = 1'b1;
            end
         end
         if (dev_q.size() < PQ_CAP) dev_q.insert(dev_pos, bus.pq_kvi);
         n_enq++;
         last_enq_cyc = cyc;
      end
      dev_size <= dev_q.size();
      dev_head <= (dev_q.size() > 0) ? dev_q[0] : '0;
   end

   assign bus.pq_full  = (dev_size == PQ_CAP);
   assign bus.pq_empty = (dev_size == 0);
   assign bus.pq_kvo   = (dev_size == 0) ? EXP_EMPTY : dev_head;

   // Background drivers for PQ busy and consumer ready.
   int   busy_mode = 0;
   bit   rdy_rand  = 1'b0;
   logic rdy_fixed = 1'b1;

   always @(posedge clk) begin
      #2;
      bus.pq_busy   = (busy_mode == 1) ? ($urandom_range(0, 3) == 0) : (busy_mode == 2);
      bus.rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
   end

   // Reference model: contents kept in arrival order; the minimum is the earliest smallest key.
   kv_t  ref_q[$];
   exp_t exp_q[$];

   function automatic int ref_min_idx();
      int idx = 0;
      for (int i = 1; i < ref_q.size(); i++)
         if (ref_q[i].key < ref_q[idx].key) idx = i;
      return idx;
   endfunction

   task automatic ref_apply(input logic [1:0] op, input kv_t kv);
      exp_t e;
      int   idx;
      case (op)
         2'b01: begin
            e.kv  = kv;
            e.err = (ref_q.size() >= PQ_CAP);
            if (!e.err) ref_q.push_back(kv);
            exp_q.push_back(e);
         end
         2'b10: begin
            if (ref_q.size() == 0) begin
               e.kv  = EXP_EMPTY;
               e.err = 1'b1;
            end else begin
               idx   = ref_min_idx();
               e.kv  = ref_q[idx];
               e.err = 1'b0;
               ref_q.delete(idx);
            end
            exp_q.push_back(e);
         end
         2'b11: begin
            if (ref_q.size() == 0) begin
               e.kv  = EXP_EMPTY;
               e.err = 1'b1;
            end else begin
               idx   = ref_min_idx();
               e.kv  = ref_q[idx];
               e.err = 1'b0;
               ref_q.delete(idx);
            end
            ref_q.push_back(kv);
            exp_q.push_back(e);
         end
         default: ;
      endcase
   endtask

   // Monitor: response scoreboard, command capture and PQ protocol checks, sampled mid-cycle.
   exp_t mon_e;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         ref_q.delete();
         check("strobe_in_reset", {30'd0, bus.pq_enq, bus.pq_deq}, 0);
      end else begin
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'(bus.rsp_valid), 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("rsp_kv", 32'(bus.rsp_kv), 32'(mon_e.kv));
               check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
            end
         end
         if (bus.req_valid && bus.req_ready) ref_apply(bus.req_op, bus.req_kv);
         if (bus.pq_enq || bus.pq_deq) begin
            check("strobe_excl", 32'(bus.pq_enq && bus.pq_deq), 0);
            check("strobe_busy", 32'(bus.pq_busy), 0);
            if (bus.pq_enq) check("enq_full", 32'(bus.pq_full), 0);
            if (bus.pq_deq) check("deq_empty", 32'(bus.pq_empty), 0);
         end
      end
   end

   // Stimulus tasks start and end at posedge + 1.
   task automatic send(input op_t op, input kv_t kv);
      int waited = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_kv    = kv;
      @(negedge clk);
      while (!bus.req_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.req_ready) check("req_timeout", 32'(bus.req_ready), 1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || cmd_count != 0 || bus.rsp_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("drain_timeout", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   int e0, d0, w, r;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_kv    = '0;

      // Reset state
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_kv", 32'(bus.rsp_kv), 0);
      check("rst_rsp_err", 32'(bus.rsp_err), 0);
      check("rst_cmd_count", 32'(cmd_count), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 32'(bus.req_ready), 1);
      @(posedge clk);
      #1;

      // 1: ENQ 5, 2, 9 then DEQ x3
      send(OP_ENQ, mk(5, 8'h51));
      send(OP_ENQ, mk(2, 8'h21));
      send(OP_ENQ, mk(9, 8'h91));
      repeat (3) send(OP_DEQ, mk(0, 0));
      drain();
      check("s1_cmd_count", 32'(cmd_count), 0);

      // 2: DEQ on empty PQ
      d0 = n_deq;
      send(OP_DEQ, mk(0, 0));
      drain();
      check("s2_no_deq", n_deq - d0, 0);

      // 3: overfill the PQ by one
      e0 = n_enq;
      for (int k = 1; k <= 5; k++) send(OP_ENQ, mk(k, 16 + k));
      drain();
      check("s3_enq_pulses", n_enq - e0, 4);
      repeat (4) send(OP_DEQ, mk(0, 0));
      drain();

      // 4: REPLACE on {3, 7}
      send(OP_ENQ, mk(3, 8'h33));
      send(OP_ENQ, mk(7, 8'h77));
      drain();
      send(OP_REPL, mk(4, 8'h44));
      drain();
      check("s4_repl_gap", last_enq_cyc - last_deq_cyc, 1);
      send(OP_DEQ, mk(0, 0));
      send(OP_DEQ, mk(0, 0));
      drain();

      // 5: back-pressure on the response channel
      rdy_fixed = 1'b0;
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 6; i++) send(OP_ENQ, mk(10 + i, i));
         end
         begin
            repeat (14) @(negedge clk);
            check("s5_cmd_count", 32'(cmd_count), 4);
            check("s5_req_ready", 32'(bus.req_ready), 0);
            check("s5_rsp_held", 32'(bus.rsp_valid), 1);
            @(posedge clk);
            #1 rdy_fixed = 1'b1;
         end
      join
      drain();
      repeat (4) send(OP_DEQ, mk(0, 0));
      drain();

      // 6: reset while the REPLACE insert is pending
      send(OP_ENQ, mk(3, 8'h3a));
      send(OP_ENQ, mk(7, 8'h7a));
      drain();
      e0 = n_enq;
      send(OP_REPL, mk(4, 8'h4a));
      w = 0;
      @(negedge clk);
      while (!bus.pq_deq && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("s6_deq_seen", 32'(bus.pq_deq), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("s6_no_enq_in_reset", 32'(bus.pq_enq), 0);
      @(posedge clk);
      #1;
      check("s6_rsp_valid", 32'(bus.rsp_valid), 0);
      check("s6_cmd_count", 32'(cmd_count), 0);
      rst = 1'b0;
      @(negedge clk);
      check("s6_enq_pulses", n_enq - e0, 0);
      @(posedge clk);
      #1;
      send(OP_DEQ, mk(0, 0));
      drain();

      // Random traffic with PQ busy and consumer stalls
      busy_mode = 1;
      rdy_rand  = 1'b1;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         if (r == 0)       send(OP_NOP, mk($urandom_range(0, 15), $urandom_range(0, 255)));
         else if (r < 7)   send(OP_ENQ, mk($urandom_range(0, 15), $urandom_range(0, 255)));
         else if (r < 12)  send(OP_DEQ, mk(0, 0));
         else              send(OP_REPL, mk($urandom_range(0, 15), $urandom_range(0, 255)));
      end
      busy_mode = 0;
      rdy_rand  = 1'b0;
      drain();
      check("final_cmd_count", 32'(cmd_count), 0);
      check("final_exp_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
